// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control encoding (also used by the decoder)
// and the execute-stage buffer state type.
package cpu_pkg;
  localparam int ALU_CTRL_W = 3;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;
endpackage

// File: rtl/alu_core.sv
// Combinational ALU: maps (alucontrol, a, b) to result and flags.
// Unassigned codes yield a zero result with illegal set.
module alu_core
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [ALU_CTRL_W-1:0] alucontrol,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic [WIDTH-1:0]      result,
  output logic                  zero,
  output logic                  ovf,
  output logic                  illegal
);
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ovf_add;
  logic             ovf_sub;

  assign sum  = a + b;
  assign diff = a - b;
  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    result  = '0;
    ovf     = 1'b0;
    illegal = 1'b0;
    case (alucontrol)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: begin
        result = sum;
        ovf    = ovf_add;
      end
      ALU_SUB: begin
        result = diff;
        ovf    = ovf_sub;
      end
      // SLT reports its sign decision but never flags overflow itself
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf_sub};
      default: illegal = 1'b1;
    endcase
  end

  assign zero = (result == '0);
endmodule

// File: rtl/alu_stage.sv
// Execute-stage ALU with a 2-entry skid buffer (main + skid) behind a
// valid/ready handshake; in_ready is registered so it never sees out_ready.
module alu_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CTRL_W-1:0] alucontrol,
  input  logic [WIDTH-1:0]      srca,
  input  logic [WIDTH-1:0]      srcb,
  input  logic [TAGW-1:0]       in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      result,
  output logic                  zero,
  output logic                  ovf,
  output logic                  illegal,
  output logic [TAGW-1:0]       out_tag
);
  localparam int EW = WIDTH + TAGW + 3;

  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_ovf;
  logic             core_illegal;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .alucontrol (alucontrol),
    .a          (srca),
    .b          (srcb),
    .result     (core_result),
    .zero       (core_zero),
    .ovf        (core_ovf),
    .illegal    (core_illegal)
  );

  logic [EW-1:0] new_entry;
  logic [EW-1:0] main_reg;
  logic [EW-1:0] skid_reg;
  buf_state_e    state_reg;
  logic          in_ready_reg;
  logic          out_valid_reg;
  logic          accept;

  assign new_entry = {in_tag, core_illegal, core_ovf, core_zero, core_result};
  assign accept    = in_valid & in_ready_reg;

  // Registers load only on accept, so idle (possibly X) operands never reach the outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= BUF_EMPTY;
      main_reg      <= '0;
      skid_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        BUF_EMPTY: begin
          if (accept) begin
            main_reg      <= new_entry;
            state_reg     <= BUF_ONE;
            out_valid_reg <= 1'b1;
          end
        end
        BUF_ONE: begin
          if (accept && out_ready) begin
            main_reg <= new_entry;
          end else if (accept) begin
            skid_reg     <= new_entry;
            state_reg    <= BUF_TWO;
            in_ready_reg <= 1'b0;
          end else if (out_ready) begin
            state_reg     <= BUF_EMPTY;
            out_valid_reg <= 1'b0;
          end
        end
        BUF_TWO: begin
          if (out_ready) begin
            main_reg     <= skid_reg;
            state_reg    <= BUF_ONE;
            in_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg     <= BUF_EMPTY;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign {out_tag, illegal, ovf, zero, result} = main_reg;
endmodule

// File: tb/tb_alu_stage.sv
// Scoreboard bench for alu_stage: accepts push model results, a negedge
// monitor pops and compares every output transfer.
module tb_alu_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  alucontrol = 3'b000;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        ovf;
  logic        illegal;
  logic [4:0]  out_tag;

  alu_stage #(.WIDTH(32), .TAGW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alucontrol(alucontrol), .srca(srca), .srcb(srcb), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .ovf(ovf), .illegal(illegal), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [39:0] q[$];
  logic rand_phase = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: signed arithmetic on 64-bit integers, result packed as {tag, illegal, ovf, zero, result}
  function automatic logic [39:0] model(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] tag);
    longint sa, sb, full;
    logic [31:0] r;
    logic v, ill;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; v = 1'b0; ill = 1'b0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin full = sa + sb; r = full[31:0]; v = (full > 64'sd2147483647) || (full < -64'sd2147483648); end
      3'b110: begin full = sa - sb; r = full[31:0]; v = (full > 64'sd2147483647) || (full < -64'sd2147483648); end
      3'b111: r = (sa < sb) ? 32'd1 : 32'd0;
      default: ill = 1'b1;
    endcase
    return {tag, ill, v, (r == 32'd0), r};
  endfunction

  // Push on accept / pop on output transfer, sampled at negedge where inputs are stable
  logic [39:0] held_val;
  logic        held_flag = 1'b0;
  always @(negedge clk) begin
    logic [39:0] act, exp;
    if (!rst_n) begin
      held_flag = 1'b0;
    end else begin
      act = {out_tag, illegal, ovf, zero, result};
      if (held_flag && out_valid) check("stall_hold", {24'd0, act}, {24'd0, held_val});
      if (in_valid && in_ready) q.push_back(model(alucontrol, srca, srcb, in_tag));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_output: got tag %0d result %h, expected nothing", out_tag, result);
        end else begin
          exp = q.pop_front();
          check("tx", {24'd0, act}, {24'd0, exp});
          $display("tx tag=%0d result=%h zero=%b ovf=%b illegal=%b", out_tag, result, zero, ovf, illegal);
        end
      end
      held_flag = out_valid && !out_ready;
      held_val  = act;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] tag, bit lat);
    bit ok;
    int n;
    in_valid = 1'b1; alucontrol = op; srca = a; srcb = b; in_tag = tag;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: tag %0d not accepted, required acceptance within 200 cycles", tag);
    end else if (lat) begin
      check("latency_valid", {63'd0, out_valid}, 64'd1);
      check("latency_tag", {59'd0, out_tag}, {59'd0, tag});
    end
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("drain_empty", {63'd0, (q.size() == 0 && !out_valid)}, 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_outputs", {24'd0, out_tag, illegal, ovf, zero, result}, 64'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Basic ops, one per cycle
    send(3'b010, 32'd5, 32'd7, 5'd1, 1'b1);
    check("in_ready_hi", {63'd0, in_ready}, 64'd1);
    send(3'b110, 32'd7, 32'd7, 5'd2, 1'b1);
    check("in_ready_hi", {63'd0, in_ready}, 64'd1);
    send(3'b000, 32'hF0F0_0000, 32'hFF00_FF00, 5'd3, 1'b1);
    send(3'b001, 32'h0000_000F, 32'h0000_00F0, 5'd4, 1'b1);
    // Signed compare and overflow corners
    send(3'b111, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);
    send(3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 5'd6, 1'b1);
    send(3'b010, 32'h7FFF_FFFF, 32'd1, 5'd7, 1'b1);
    send(3'b110, 32'h8000_0000, 32'd1, 5'd8, 1'b1);
    drain();

    // Backpressure: two accepted, third waits
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(3'b010, 32'd10, 32'd1, 5'd1, 1'b0);
    send(3'b010, 32'd20, 32'd2, 5'd2, 1'b0);
    check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    check("bp_hold_tag", {59'd0, out_tag}, 64'd1);
    fork
      send(3'b010, 32'd30, 32'd3, 5'd3, 1'b0);
      begin
        repeat (3) begin
          @(posedge clk); #1;
          check("bp_stall_tag", {59'd0, out_tag}, 64'd1);
          check("bp_stall_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Back-to-back throughput
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++)
      send(3'($urandom_range(0, 7)), $urandom, $urandom, 5'(i + 10), 1'b1);
    drain();

    // Illegal code, then a legal op clears the flag
    @(posedge clk); #1;
    send(3'b100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd9, 1'b1);
    check("illegal_flag", {60'd0, illegal, ovf, zero, (result == 32'd0)}, 64'hB);
    send(3'b001, 32'd1, 32'd2, 5'd10, 1'b1);
    check("illegal_clear", {63'd0, illegal}, 64'd0);
    drain();

    // Randomized traffic with random backpressure and idle X operands
    @(posedge clk); #1;
    rand_phase = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0; srca = 'x; srcb = 'x;
            @(posedge clk); #1;
          end
          send(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom), 1'b0);
        end
        rand_phase = 1'b0;
      end
      begin
        while (rand_phase) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk); #1;
        end
      end
    join
    drain();

    // Asynchronous reset while in TWO
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(3'b010, 32'd1, 32'd1, 5'd20, 1'b0);
    send(3'b010, 32'd2, 32'd2, 5'd21, 1'b0);
    check("pre_rst_two", {63'd0, in_ready}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst_ready", {63'd0, in_ready}, 64'd1);
    check("async_rst_outputs", {24'd0, out_tag, illegal, ovf, zero, result}, 64'd0);
    q.delete();
    @(negedge clk); #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(3'b010, 32'd100, 32'd23, 5'd22, 1'b1);
    check("post_rst_result", {32'd0, result}, 64'd123);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
